// File: rtl/modn_counter_bcd_if.sv
// Bus bundle for the modulo-N BCD counter: control inputs and
// count/strobe/digit outputs, with master (driver) and slave (counter) views.
interface modn_counter_bcd_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             carry;
  logic             load_err;
  logic [3:0]       tens;
  logic [3:0]       ones;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tick, carry, load_err, tens, ones
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tick, carry, load_err, tens, ones
  );
endinterface

// File: rtl/modn_counter_bcd.sv
// Modulo-MOD up/down counter with enable-gated prescaler, synchronous
// load, wrap carry pulse and registered two-digit BCD outputs.
module modn_counter_bcd #(
  parameter int MOD      = 12,
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4000000,
  parameter int PS_W     = 22
) (
  input  logic              clk,
  input  logic              reset,
  modn_counter_bcd_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_X   = (WIDTH + 1)'(MOD);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nx;
  logic [PS_W-1:0]  presc;
  logic [PS_W-1:0]  presc_nx;
  logic             carry;
  logic             carry_nx;
  logic             err;
  logic             err_nx;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [7:0]       bcd;
  logic             tick;
  logic             load_ok;

  function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
    int n;
    int t;
    n = int'(v);
    t = 0;
    for (int i = 1; i < 10; i++) begin
      if (n >= 10 * i) t = i;
    end
    return {4'(t), 4'(n - 10 * t)};
  endfunction

  assign tick    = bus.en && (presc == PS_LAST);
  assign load_ok = ({1'b0, bus.load_val} < MOD_X);
  assign bcd     = to_bcd(cnt);

  always_comb begin
    cnt_nx   = cnt;
    presc_nx = presc;
    carry_nx = 1'b0;
    err_nx   = 1'b0;
    if (bus.load) begin
      // A rejected load also suppresses the step for that cycle.
      if (load_ok) begin
        cnt_nx   = bus.load_val;
        presc_nx = '0;
      end else begin
        err_nx = 1'b1;
      end
    end else if (bus.en) begin
      if (tick) begin
        presc_nx = '0;
        if (bus.up_dn) begin
          if (cnt == LAST) begin
            cnt_nx   = '0;
            carry_nx = 1'b1;
          end else begin
            cnt_nx = cnt + WIDTH'(1);
          end
        end else begin
          if (cnt == '0) begin
            cnt_nx   = LAST;
            carry_nx = 1'b1;
          end else begin
            cnt_nx = cnt - WIDTH'(1);
          end
        end
      end else begin
        presc_nx = presc + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      presc <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      cnt   <= cnt_nx;
      presc <= presc_nx;
      carry <= carry_nx;
      err   <= err_nx;
      tens  <= bcd[7:4];
      ones  <= bcd[3:0];
    end
  end

  assign bus.count    = cnt;
  assign bus.tick     = tick;
  assign bus.carry    = carry;
  assign bus.load_err = err;
  assign bus.tens     = tens;
  assign bus.ones     = ones;

endmodule

// File: tb/tb_modn_counter_bcd.sv
// Scoreboard bench for modn_counter_bcd: three parameterisations, directed
// vectors with hand-computed expectations, checked by a decoupled monitor.
module tb_modn_counter_bcd;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modn_counter_bcd_if #(.WIDTH(4)) ia ();
  modn_counter_bcd_if #(.WIDTH(4)) ib ();
  modn_counter_bcd_if #(.WIDTH(6)) ic ();

  modn_counter_bcd #(
    .MOD(12), .WIDTH(4), .PRESCALE(1), .PS_W(1)
  ) ua (.clk(clk), .reset(reset), .bus(ia));

  modn_counter_bcd #(
    .MOD(12), .WIDTH(4), .PRESCALE(4), .PS_W(2)
  ) ub (.clk(clk), .reset(reset), .bus(ib));

  modn_counter_bcd #(
    .MOD(60), .WIDTH(6), .PRESCALE(1), .PS_W(1)
  ) uc (.clk(clk), .reset(reset), .bus(ic));

  typedef struct {
    int         id;
    string      nm;
    logic [6:0] count;
    logic       tick;
    logic       carry;
    logic       load_err;
    logic [3:0] tens;
    logic [3:0] ones;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic drive(input int id, input logic e, input logic ud,
                       input logic ld, input logic [6:0] lv);
    case (id)
      0: begin
        ia.en = e; ia.up_dn = ud; ia.load = ld; ia.load_val = lv[3:0];
      end
      1: begin
        ib.en = e; ib.up_dn = ud; ib.load = ld; ib.load_val = lv[3:0];
      end
      default: begin
        ic.en = e; ic.up_dn = ud; ic.load = ld; ic.load_val = lv[5:0];
      end
    endcase
  endtask

  task automatic push(input int id, input string nm, input int c,
                      input logic tk, input logic cy, input logic le,
                      input int t, input int o);
    exp_t x;
    x.id = id; x.nm = nm; x.count = 7'(c);
    x.tick = tk; x.carry = cy; x.load_err = le;
    x.tens = 4'(t); x.ones = 4'(o);
    q.push_back(x);
  endtask

  task automatic vec(input int id, input string nm, input logic e,
                     input logic ud, input logic ld, input int lv,
                     input int c, input logic tk, input logic cy,
                     input logic le, input int t, input int o);
    drive(id, e, ud, ld, 7'(lv));
    push(id, nm, c, tk, cy, le, t, o);
    @(negedge clk);
  endtask

  task automatic push_zero(input string nm);
    for (int i = 0; i < 3; i++) push(i, nm, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: samples just after each clock edge or reset assertion.
  always @(posedge clk or posedge reset) begin
    #1;
    while (q.size() > 0) begin
      exp_t x;
      logic [6:0] c;
      logic tk, cy, le;
      logic [3:0] t, o;
      x = q.pop_front();
      case (x.id)
        0: begin
          c = 7'(ia.count); tk = ia.tick; cy = ia.carry;
          le = ia.load_err; t = ia.tens; o = ia.ones;
        end
        1: begin
          c = 7'(ib.count); tk = ib.tick; cy = ib.carry;
          le = ib.load_err; t = ib.tens; o = ib.ones;
        end
        default: begin
          c = 7'(ic.count); tk = ic.tick; cy = ic.carry;
          le = ic.load_err; t = ic.tens; o = ic.ones;
        end
      endcase
      n_vec++;
      if ({c, tk, cy, le, t, o} !==
          {x.count, x.tick, x.carry, x.load_err, x.tens, x.ones}) begin
        n_bad++;
        $display("FAIL %s dut%0d @%0t: got cnt=%0d tick=%b carry=%b err=%b bcd=%0d/%0d, want cnt=%0d tick=%b carry=%b err=%b bcd=%0d/%0d",
                 x.nm, x.id, $time, c, tk, cy, le, t, o,
                 x.count, x.tick, x.carry, x.load_err, x.tens, x.ones);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b1, 1'b0, 7'd0);
    @(negedge clk);
    push_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // ua: full up cycle with wrap
    for (int k = 1; k <= 13; k++)
      vec(0, "up12", 1, 1, 0, 0, k % 12, 1, k == 12, 0,
          ((k - 1) % 12) / 10, ((k - 1) % 12) % 10);

    // down from 0 wraps to 11
    vec(0, "ld0",   1, 1, 1, 0,  0, 1, 0, 0, 0, 1);
    vec(0, "dn12",  1, 0, 0, 0, 11, 1, 1, 0, 0, 0);
    vec(0, "dn12",  1, 0, 0, 0, 10, 1, 0, 0, 1, 1);
    vec(0, "dn12",  1, 0, 0, 0,  9, 1, 0, 0, 1, 0);
    vec(0, "dn12",  1, 0, 0, 0,  8, 1, 0, 0, 0, 9);
    vec(0, "lderr", 1, 0, 1, 12, 8, 1, 0, 1, 0, 8);
    vec(0, "hold",  0, 0, 0, 0,  8, 0, 0, 0, 0, 8);

    // PRESCALE=4: one step per four enabled cycles
    for (int k = 1; k <= 8; k++)
      vec(1, "ps4", 1, 1, 0, 0, k / 4, (k % 4) == 3, 0, 0, 0, (k - 1) / 4);
    vec(1, "gap", 1, 1, 0, 0, 2, 0, 0, 0, 0, 2);
    vec(1, "gap", 1, 1, 0, 0, 2, 0, 0, 0, 0, 2);
    for (int k = 0; k < 3; k++)
      vec(1, "gap_off", 0, 1, 0, 0, 2, 0, 0, 0, 0, 2);
    vec(1, "gap", 1, 1, 0, 0, 2, 1, 0, 0, 0, 2);
    vec(1, "gap_step", 1, 1, 0, 0, 3, 0, 0, 0, 0, 2);
    vec(1, "ps4", 1, 1, 0, 0, 3, 0, 0, 0, 0, 3);
    vec(1, "ps4", 1, 1, 0, 0, 3, 0, 0, 0, 0, 3);
    vec(1, "ps4", 1, 1, 0, 0, 3, 1, 0, 0, 0, 3);

    // load on a tick cycle: load wins, prescaler restarts
    vec(1, "ld7",   1, 1, 1, 7, 7, 0, 0, 0, 0, 3);
    vec(1, "ld7p",  1, 1, 0, 0, 7, 0, 0, 0, 0, 7);
    vec(1, "ld7p",  1, 1, 0, 0, 7, 0, 0, 0, 0, 7);
    vec(1, "ld7p",  1, 1, 0, 0, 7, 1, 0, 0, 0, 7);
    vec(1, "ld7st", 1, 1, 0, 0, 8, 0, 0, 0, 0, 7);
    vec(1, "idle",  0, 1, 0, 0, 8, 0, 0, 0, 0, 8);

    // uc: two-digit values and wraps
    vec(2, "ld59",   0, 1, 1, 59, 59, 0, 0, 0, 0, 0);
    vec(2, "bcd59",  0, 1, 0, 0,  59, 0, 0, 0, 5, 9);
    vec(2, "wrap60", 1, 1, 0, 0,   0, 1, 1, 0, 5, 9);
    vec(2, "bcd0",   0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    vec(2, "dn60",   1, 0, 0, 0,  59, 1, 1, 0, 0, 0);
    vec(2, "bcd59b", 0, 0, 0, 0,  59, 0, 0, 0, 5, 9);
    vec(2, "err60",  0, 0, 1, 60, 59, 0, 0, 1, 5, 9);
    vec(2, "hold60", 0, 0, 0, 0,  59, 0, 0, 0, 5, 9);

    // async reset between edges mid-count
    vec(0, "pre", 1, 1, 0, 0,  9, 1, 0, 0, 0, 8);
    vec(0, "pre", 1, 1, 0, 0, 10, 1, 0, 0, 0, 9);
    drive(0, 1'b0, 1'b1, 1'b0, 7'd0);
    push_zero("rst_async");
    #2;
    reset = 1'b1;
    @(negedge clk);
    push_zero("rst_held");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++)
      vec(1, "rst_rs", 1, 1, 0, 0, k / 4, (k % 4) == 3, 0, 0, 0, (k - 1) / 4);
    drive(1, 1'b0, 1'b1, 1'b0, 7'd0);

    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
